// File: rtl/uart_tx_framer.sv
// UART transmitter with a small input FIFO; frames queued words onto uart_tx
// with configurable data width, parity, stop bits and bit period.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [CW-1:0] LAST_BAUD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 push, pop, full, empty;
  logic [DATA_BITS-1:0] head;

  state_t               state_reg, state_next;
  logic [CW-1:0]        baud_reg, baud_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 bit_end, load;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == DEPTH_L);
  assign empty      = (fifo_level == '0);
  assign tx_ready   = !full;
  assign push       = tx_valid && !full;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
    end
  end

  assign bit_end = (baud_reg == LAST_BAUD);

  // tx_next is the value the line takes after this edge, so uart_tx stays a pure register.
  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    load        = 1'b0;
    pop         = 1'b0;

    if (state_reg != S_IDLE) baud_next = bit_end ? '0 : baud_reg + BAUD_ONE;

    case (state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        if (!empty) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          tx_next    = shift_reg[0];
          bit_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_reg == LAST_DATA) begin
            bit_next = '0;
            if (PARITY != 0) begin
              state_next = S_PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
            bit_next   = bit_reg + BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
          bit_next   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_reg == LAST_STOP) begin
            if (!empty) load = 1'b1;
            else begin
              state_next = S_IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_reg + BIT_ONE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Pop the head straight into the shifter; the start bit goes out on this edge.
    if (load) begin
      pop         = 1'b1;
      state_next  = S_START;
      shift_next  = head;
      parity_next = (^head) ^ ODD;
      tx_next     = 1'b0;
      baud_next   = '0;
      bit_next    = '0;
    end
  end

  assign uart_tx = tx_reg;
  assign busy    = (state_reg != S_IDLE) || !empty;

endmodule
